// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcode encoding, legality
// bounds and sequencer state encoding.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [4:0] OPCODE_MIN = OP_ADD;
    localparam logic [4:0] OPCODE_MAX = OP_NOT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic opcode_legal(input logic [4:0] op);
        return (op >= OPCODE_MIN) && (op <= OPCODE_MAX);
    endfunction

endpackage

// File: rtl/alu_latency_lut.sv
// Maps an ALU opcode to its execution latency in cycles and flags whether the
// opcode is one the ALU implements.
module alu_latency_lut
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned DIV_CYCLES  = 8,
    parameter int unsigned BASE_CYCLES = 1
) (
    input  logic [4:0] opcode,
    output logic [3:0] lat,
    output logic       legal
);

    // Immediate forms share the base latency with their register forms.
    always_comb begin
        legal = opcode_legal(opcode);
        lat   = 4'(BASE_CYCLES);
        if (opcode == OP_MUL) begin
            lat = 4'(MUL_CYCLES);
        end else if (opcode == OP_DIV) begin
            lat = 4'(DIV_CYCLES);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side ALU controller: accepts one request, holds operands on the ALU for
// the opcode's latency, captures the 64-bit result into Z and returns it.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned DIV_CYCLES  = 8,
    parameter int unsigned BASE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_ra,
    input  logic [31:0] req_rb,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [31:0] y_reg;
    logic [31:0] b_reg;
    logic [4:0]  op_reg;
    logic [63:0] z_reg;
    logic [3:0]  cnt;
    logic        err_reg;
    logic [3:0]  lat;
    logic        legal;
    logic        fault;
    logic        accept;

    alu_latency_lut #(
        .MUL_CYCLES  (MUL_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .BASE_CYCLES (BASE_CYCLES)
    ) u_latency_lut (
        .opcode (req_opcode),
        .lat    (lat),
        .legal  (legal)
    );

    // Requests that can never produce a meaningful ALU result skip EXEC entirely.
    assign fault  = !legal || ((req_opcode == OP_DIV) && (req_rb == 32'd0));
    assign req_ready = clear_n && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fault ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        state_next = fault ? RESP : EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Z only changes on a faulting accept or at the end of EXEC, so it stays
    // stable for the whole response handshake regardless of alu_c.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            y_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            z_reg   <= '0;
            cnt     <= '0;
            err_reg <= 1'b0;
        end else if (accept) begin
            y_reg  <= req_ra;
            b_reg  <= req_rb;
            op_reg <= req_opcode;
            cnt    <= lat - 4'd1;
            if (fault) begin
                z_reg   <= '0;
                err_reg <= 1'b1;
            end
        end else if (state == EXEC) begin
            if (cnt == 4'd0) begin
                z_reg   <= alu_c;
                err_reg <= 1'b0;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign alu_a      = y_reg;
    assign alu_b      = b_reg;
    assign alu_opcode = op_reg;
    assign rsp_hi     = z_reg[63:32];
    assign rsp_lo     = z_reg[31:0];
    assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a transaction-level model with an ALU that only
// presents a valid result while an operation is executing.
module tb_alu_sequencer;

    localparam int unsigned MUL_CYCLES  = 4;
    localparam int unsigned DIV_CYCLES  = 8;
    localparam int unsigned BASE_CYCLES = 1;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = '0;
    logic [31:0] req_ra = '0;
    logic [31:0] req_rb = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;
    int cycle_no = 0;

    bit          m_exec = 1'b0;
    int          m_due = 0;
    logic [63:0] m_pend = '0;
    bit          m_resp = 1'b0;
    logic [63:0] m_z = '0;
    bit          m_err = 1'b0;
    logic [31:0] m_y = '0;
    logic [31:0] m_b = '0;
    logic [4:0]  m_op = '0;
    bit          m_accepted = 1'b0;
    logic [63:0] noise = '0;

    alu_sequencer #(
        .MUL_CYCLES  (MUL_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .BASE_CYCLES (BASE_CYCLES)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_ra     (req_ra),
        .req_rb     (req_rb),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] r;
        logic [4:0]  s;
        s = b[4:0];
        r = '0;
        case (op)
            5'd3, 5'd12: r = {32'h0, a + b};
            5'd4:        r = {32'h0, a - b};
            5'd5, 5'd13: r = {32'h0, a & b};
            5'd6, 5'd14: r = {32'h0, a | b};
            5'd7:        r = {32'h0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            5'd8:        r = {32'h0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            5'd9:        r = {32'h0, a >> s};
            5'd10:       r = {32'h0, 32'($signed(a) >>> s)};
            5'd11:       r = {32'h0, a << s};
            5'd15:       r = (b == 32'd0) ? 64'd0 : {a / b, a % b};
            5'd16:       r = 64'(a) * 64'(b);
            5'd17:       r = {32'h0, 32'd0 - a};
            5'd18:       r = {32'h0, ~a};
            default:     r = '0;
        endcase
        return r;
    endfunction

    function automatic int op_latency(input logic [4:0] op);
        if (op == 5'd16) return int'(MUL_CYCLES);
        if (op == 5'd15) return int'(DIV_CYCLES);
        return int'(BASE_CYCLES);
    endfunction

    // The ALU only drives a real result while the model says an op is executing.
    assign alu_c = m_exec ? alu_ref(alu_opcode, alu_a, alu_b) : noise;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [31:0] ra,
                                 input logic [31:0] rb, input logic rready);
        req_valid  = valid;
        req_opcode = op;
        req_ra     = ra;
        req_rb     = rb;
        rsp_ready  = rready;
    endtask

    task automatic model_reset();
        m_exec = 1'b0; m_resp = 1'b0; m_z = '0; m_err = 1'b0;
        m_y = '0; m_b = '0; m_op = '0; m_accepted = 1'b0;
    endtask

    task automatic model_edge();
        bit ready;
        m_accepted = 1'b0;
        if (!clear_n) return;
        ready = (!m_exec && !m_resp) || (m_resp && rsp_ready);
        if (m_resp && rsp_ready) m_resp = 1'b0;
        cycle_no++;
        if (m_exec && cycle_no == m_due) begin
            m_exec = 1'b0; m_resp = 1'b1; m_z = m_pend; m_err = 1'b0;
        end
        if (req_valid && ready) begin
            m_accepted = 1'b1;
            m_y = req_ra; m_b = req_rb; m_op = req_opcode;
            if (req_opcode < 5'd3 || req_opcode > 5'd18 || (req_opcode == 5'd15 && req_rb == 32'd0)) begin
                m_resp = 1'b1; m_z = '0; m_err = 1'b1;
            end else begin
                m_exec = 1'b1;
                m_due  = cycle_no + op_latency(req_opcode);
                m_pend = alu_ref(req_opcode, req_ra, req_rb);
            end
        end
    endtask

    task automatic compare_model();
        bit exp_ready;
        exp_ready = clear_n && ((!m_exec && !m_resp) || (m_resp && rsp_ready));
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_resp));
        checkOutput("alu_a", 64'(alu_a), 64'(m_y));
        checkOutput("alu_b", 64'(alu_b), 64'(m_b));
        checkOutput("alu_opcode", 64'(alu_opcode), 64'(m_op));
        if (m_resp || !clear_n) begin
            checkOutput("rsp_z", {rsp_hi, rsp_lo}, m_z);
            checkOutput("rsp_err", 64'(rsp_err), 64'(m_err));
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        @(negedge clock);
        compare_model();
        noise = {$urandom, $urandom};
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 1;
        while (!rsp_valid && n < 30) begin
            checkOutput({name, "_ready_busy"}, 64'(req_ready), 64'd0);
            step();
            n++;
        end
    endtask

    task automatic run_directed(input string name, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int exp_cycles,
                                input logic [63:0] exp_z, input logic exp_err);
        int n;
        applyStimulus(1'b1, op, a, b, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        wait_rsp(name, n);
        checkOutput({name, "_latency"}, 64'(n), 64'(exp_cycles));
        checkOutput({name, "_z"}, {rsp_hi, rsp_lo}, exp_z);
        checkOutput({name, "_err"}, 64'(rsp_err), 64'(exp_err));
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        checkOutput("reset_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_valid", 64'(rsp_valid), 64'd0);
        clear_n = 1'b1;
        step();
        checkOutput("ready_after_release", 64'(req_ready), 64'd1);

        run_directed("add", 5'd3, 32'd5, 32'd3, 2, 64'h0000_0000_0000_0008, 1'b0);
        run_directed("mul", 5'd16, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0001_FFFF_FFFE, 1'b0);
        run_directed("div", 5'd15, 32'd17, 32'd5, 9, 64'h0000_0003_0000_0002, 1'b0);
        run_directed("div0", 5'd15, 32'd17, 32'd0, 1, 64'd0, 1'b1);
        run_directed("ill0", 5'd0, 32'd9, 32'd9, 1, 64'd0, 1'b1);
        run_directed("ill31", 5'd31, 32'd9, 32'd9, 1, 64'd0, 1'b1);

        // Backpressure, then a new request accepted in the handshake cycle.
        applyStimulus(1'b1, 5'd4, 32'd100, 32'd58, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        wait_rsp("bp", n);
        checkOutput("bp_first_lo", 64'(rsp_lo), 64'd42);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("bp_hold_valid", 64'(rsp_valid), 64'd1);
            checkOutput("bp_hold_lo", 64'(rsp_lo), 64'd42);
        end
        applyStimulus(1'b1, 5'd6, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        #1;
        checkOutput("bp_ready_same_cycle", 64'(req_ready), 64'd1);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("bp_next_busy", 64'(rsp_valid), 64'd0);
        step();
        checkOutput("bp_next_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_next_lo", 64'(rsp_lo), 64'h0000_00FF);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        step();

        // Abort a multiply mid-EXEC with an asynchronous reset.
        applyStimulus(1'b1, 5'd16, 32'd7, 32'd9, 1'b1);
        step();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        step();
        step();
        clear_n = 1'b0;
        model_reset();
        #1;
        checkOutput("abort_valid", 64'(rsp_valid), 64'd0);
        checkOutput("abort_ready", 64'(req_ready), 64'd0);
        checkOutput("abort_z", {rsp_hi, rsp_lo}, 64'd0);
        step();
        step();
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        run_directed("after_abort", 5'd3, 32'h1234_0000, 32'h0000_5678, 2, 64'h0000_0000_1234_5678, 1'b0);

        // Randomized traffic; an unaccepted request is held unchanged.
        for (int i = 0; i < 800; i++) begin
            if (!req_valid || m_accepted) begin
                req_valid = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) == 0) req_opcode = 5'($urandom_range(0, 31));
                else req_opcode = 5'($urandom_range(3, 18));
                req_ra = $urandom;
                req_rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the datapath ALU. Accepts one operation request over a valid/ready handshake and loads the Y (A-operand) and B-operand registers.
- Drives the ALU opcode and operands, waits the per-opcode execution latency, then captures the 64-bit ALU result into Z (ZHI/ZLO).
- Returns Z on a valid/ready response handshake. Sits between the control unit and the ALU; it is the producer of ALU inputs and the consumer of ALU output C.

Parameters:
- MUL_CYCLES, 4, EXEC cycles held for Multiply (multicycle path through the multiplier); range 1..15
- DIV_CYCLES, 8, EXEC cycles held for Divide; range 1..15
- BASE_CYCLES, 1, EXEC cycles for all other legal opcodes; range 1..15

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_opcode  in  5  ALU opcode (alu_pkg encoding)
- req_ra  in  32  operand loaded into Y
- req_rb  in  32  operand B; immediates arrive already sign-extended
- alu_a  out  32  to ALU A (Y register)
- alu_b  out  32  to ALU B (B register)
- alu_opcode  out  5  to ALU opcode
- alu_c  in  64  ALU result C
- rsp_valid  out  1  Z result available
- rsp_ready  in  1  consumer takes result
- rsp_hi  out  32  ZHI = C[63:32] (Divide: quotient; Multiply: upper product)
- rsp_lo  out  32  ZLO = C[31:0] (Divide: remainder)
- rsp_err  out  1  illegal opcode or divide by zero

Behaviour:
- Reset (clear_n low, asynchronous): state IDLE; Y, B, opcode, Z, cnt, and err registers all 0; req_ready=0 while clear_n low and 1 from the first cycle after release; rsp_valid=0.
- Outputs alu_a/alu_b/alu_opcode are direct register outputs (Y, B, op_reg).
- States:
  - IDLE: req_ready=1. On req_valid, latch Y<=req_ra, B<=req_rb, op_reg<=req_opcode.
    - Legal opcode: go to EXEC with cnt=lat-1.
    - Illegal opcode (outside 5'b00011..5'b10010): go straight to RESP with Z=0 and err=1. The ALU opcode register still updates; the ALU output is ignored.
    - Divide with req_rb==0: go straight to RESP with Z=0 and err=1. The ALU is not waited on.
  - EXEC: cnt decrements each cycle. When cnt==0, Z<={alu_c[63:32],alu_c[31:0]}, err=0, go to RESP.
  - RESP: rsp_valid=1; rsp_hi/rsp_lo/rsp_err are stable until the handshake. When rsp_ready=1 the response completes. If req_valid=1 in the same cycle, the new request is accepted (req_ready=rsp_ready in RESP) with IDLE acceptance rules; otherwise go to IDLE.
- Latency: request accepted at edge k gives rsp_valid high from cycle k+lat+1, where lat = MUL_CYCLES, DIV_CYCLES, or BASE_CYCLES by opcode. Error paths give rsp_valid at k+1.
- Latency rules:
  - Add/AddImmediate, AND/ANDImmediate, and OR/ORImmediate use BASE_CYCLES; the sequencer does not distinguish immediate forms.
  - Shift and rotate amounts are passed unmodified in B.
- req_ready is low throughout EXEC; requests presented then are held by the requester, not dropped.
- Back-to-back throughput: one operation per lat+1 cycles with rsp_ready held high.
- Reset during EXEC or RESP aborts the operation. No response is emitted for it, and Z clears.
- Z is not updated in RESP even if alu_c changes.

Decomposition:
- alu_pkg holds:
  - the opcode constants (Add 00011 .. NOT 10010, matching the ALU);
  - the state encoding (IDLE, EXEC, RESP);
  - the OPCODE_MIN/OPCODE_MAX legality bounds.
- One combinational sub-module, alu_latency_lut: takes opcode plus the three parameters and produces lat[3:0] and a legal flag. The FSM, counter, and operand/Z registers stay in alu_sequencer.

Test Plan:
- Reset/idle: clear_n low mid-cycle -> rsp_valid=0, req_ready=0 and Z=0 immediately; req_ready=1 the cycle after release.
- Add: A=0x00000005, B=0x00000003, opcode 00011, ALU model returns C=8 -> rsp_valid at k+2, rsp_hi=0, rsp_lo=0x00000008, rsp_err=0.
- Multiply: A=0xFFFFFFFF, B=2, opcode 10000 -> rsp_valid exactly at k+5; {hi,lo}=0x00000001_FFFFFFFE; req_ready low for all 4 EXEC cycles.
- Divide: A=17, B=5 -> rsp_valid at k+9, rsp_hi=3, rsp_lo=2. Divide with B=0 -> rsp_valid at k+1, rsp_err=1, hi=lo=0.
- Illegal opcode 00000 and 11111 -> rsp_valid at k+1, rsp_err=1, Z=0.
- Backpressure/back-to-back: hold rsp_ready=0 for 3 cycles -> response stable. Then raise rsp_ready with req_valid=1 (OR 0xF0|0x0F) in the same cycle -> new request accepted in that cycle, next rsp_lo=0xFF at +2.
- Abort: assert clear_n low during Multiply EXEC -> no response; the next request completes normally.
